// File: rtl/mac_pe_dot_if.sv
// mac_pe_dot_if: operand-beat and result handshake bundle for the dot-product MAC PE.
// The master side is the operand streamer / result collector, the slave side is the PE.
interface mac_pe_dot_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 8
);
    logic [NUM_LANES*DATA_WIDTH-1:0] a_i;
    logic [NUM_LANES*DATA_WIDTH-1:0] b_i;
    logic                            in_valid_i;
    logic                            in_ready_o;
    logic                            signed_i;
    logic                            sat_en_i;
    logic [CNT_WIDTH-1:0]            k_len_i;
    logic                            acc_clr_i;
    logic [ACC_WIDTH-1:0]            out_data_o;
    logic                            out_ovf_o;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic                            busy_o;

    modport master (
        output a_i, b_i, in_valid_i, signed_i, sat_en_i, k_len_i, acc_clr_i, out_ready_i,
        input  in_ready_o, out_data_o, out_ovf_o, out_valid_o, busy_o
    );

    modport slave (
        input  a_i, b_i, in_valid_i, signed_i, sat_en_i, k_len_i, acc_clr_i, out_ready_i,
        output in_ready_o, out_data_o, out_ovf_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/mac_pe_dot.sv
// mac_pe_dot: pipelined dot-product MAC processing element.
// Stage 1 registers NUM_LANES lane products, stage 2 reduces them and accumulates
// over K beats with optional saturation; the result is held until the collector takes it.
module mac_pe_dot #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 8
) (
    input logic         clk_i,
    input logic         rst_ni,
    mac_pe_dot_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;  // one lane product
    localparam int SW = ACC_WIDTH + 1;   // sum width with one guard bit for overflow

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN1,
        S_DRAIN2,
        S_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic                 clr, accept, eff_signed;
    logic [CNT_WIDTH-1:0] cnt_q, k_q, k_first;
    logic                 signed_q, sat_q;
    logic [PW-1:0]        prod_d [NUM_LANES];
    logic [PW-1:0]        prod_q [NUM_LANES];
    logic                 p_valid_q, p_first_q;
    logic [SW-1:0]        sum_d, base, total;
    logic [ACC_WIDTH-1:0] acc_q, acc_next;
    logic                 ovf_q, ovf_pos, ovf_neg;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic                 out_ovf_q, out_valid_q;

    function automatic logic [PW-1:0] ext_op(input logic [DATA_WIDTH-1:0] v, input logic sgn);
        return {{DATA_WIDTH{sgn & v[DATA_WIDTH-1]}}, v};
    endfunction

    assign clr            = bus.acc_clr_i;
    assign bus.in_ready_o = ((state_q == S_IDLE) || (state_q == S_ACCUM)) && !clr;
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign k_first        = (bus.k_len_i == '0) ? CNT_WIDTH'(1) : bus.k_len_i;
    // The first beat's products use the live mode bit; later beats use the latched one.
    assign eff_signed     = (state_q == S_IDLE) ? bus.signed_i : signed_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of block order.
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state: job start, last beat, two drain cycles, result hold; abort wins.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = (k_first == CNT_WIDTH'(1)) ? S_DRAIN1 : S_ACCUM;
            S_ACCUM:  if (accept && (cnt_q + CNT_WIDTH'(1) == k_q)) state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_HOLD;
            S_HOLD:   if (out_valid_q && bus.out_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    // Job control: beat count, job length and mode bits captured on the first beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            k_q      <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            if (state_q == S_IDLE) begin
                cnt_q    <= CNT_WIDTH'(1);
                k_q      <= k_first;
                signed_q <= bus.signed_i;
                sat_q    <= bus.sat_en_i;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Stage 1: per-lane operand extension and multiplication.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_d[i] = ext_op(bus.a_i[i*DATA_WIDTH +: DATA_WIDTH], eff_signed)
                      * ext_op(bus.b_i[i*DATA_WIDTH +: DATA_WIDTH], eff_signed);
        end
    end

    // Stage 1 qualifiers: product valid and first-beat-of-job marker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
        end else if (clr) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
        end else begin
            p_valid_q <= accept;
            p_first_q <= accept && (state_q == S_IDLE);
        end
    end

    // Stage 1 product register.
    always_ff @(posedge clk_i) begin
        // NOTE: product data has no reset; p_valid_q alone decides whether it is consumed.
        if (accept) begin
            for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_d[i];
        end
    end

    // Stage 2: reduce the products, add to the accumulator and classify overflow.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_d = sum_d + {{(SW-PW){signed_q & prod_q[i][PW-1]}}, prod_q[i]};
        end
        base     = p_first_q ? '0 : {signed_q & acc_q[ACC_WIDTH-1], acc_q};
        total    = base + sum_d;
        ovf_pos  = signed_q ? (!total[SW-1] && total[SW-2]) : total[SW-1];
        ovf_neg  = signed_q && total[SW-1] && !total[SW-2];
        acc_next = total[ACC_WIDTH-1:0];
        if (sat_q && ovf_pos)      acc_next = signed_q ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : '1;
        else if (sat_q && ovf_neg) acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end

    // Stage 2 accumulator and sticky overflow; a saturated accumulator stays clamped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (p_valid_q && (p_first_q || !(sat_q && ovf_q))) begin
            acc_q <= acc_next;
            ovf_q <= (ovf_q & !p_first_q) | ovf_pos | ovf_neg;
        end
    end

    // Result registers: loaded at the end of drain, held until the output handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (state_q == S_DRAIN2) begin
            out_data_q  <= acc_q;
            out_ovf_q   <= ovf_q;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data_o  = out_data_q;
    assign bus.out_ovf_o   = out_ovf_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mac_pe_dot.sv
// tb_mac_pe_dot: directed and randomized checks of mac_pe_dot.
// Two PEs (32-bit and 18-bit accumulators) share one stimulus stream; every result is
// compared against an arithmetic reference model of the dot product with wrap/saturate.
module tb_mac_pe_dot;
    localparam int DW = 8;
    localparam int NL = 4;
    localparam int CW = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] beat_a [16];
    logic [31:0] beat_b [16];

    always #5 clk_i = ~clk_i;

    mac_pe_dot_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(32), .CNT_WIDTH(CW)) bm ();
    mac_pe_dot_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(18), .CNT_WIDTH(CW)) bs ();

    assign bs.a_i         = bm.a_i;
    assign bs.b_i         = bm.b_i;
    assign bs.in_valid_i  = bm.in_valid_i;
    assign bs.signed_i    = bm.signed_i;
    assign bs.sat_en_i    = bm.sat_en_i;
    assign bs.k_len_i     = bm.k_len_i;
    assign bs.acc_clr_i   = bm.acc_clr_i;
    assign bs.out_ready_i = bm.out_ready_i;

    mac_pe_dot #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(32), .CNT_WIDTH(CW)) u_dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bm)
    );

    mac_pe_dot #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(18), .CNT_WIDTH(CW)) u_sat (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bs)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint lane_val(input logic [31:0] w, input int l, input logic sgn);
        logic [7:0] x;
        x = w[l*8 +: 8];
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Reference: exact dot products accumulated as integers, then range-checked per beat.
    function automatic logic [63:0] model(input int aw, input logic sgn, input logic sat,
                                          input int nb, output logic ovf);
        longint m, hi, lo, acc, s, t;
        logic   clamped;
        m   = longint'(1) << aw;
        hi  = sgn ? (m / 2 - 1) : (m - 1);
        lo  = sgn ? -(m / 2) : 0;
        acc = 0;
        ovf = 1'b0;
        clamped = 1'b0;
        for (int j = 0; j < nb; j++) begin
            s = 0;
            for (int l = 0; l < NL; l++) s += lane_val(beat_a[j], l, sgn) * lane_val(beat_b[j], l, sgn);
            if (!clamped) begin
                t = acc + s;
                if (t > hi || t < lo) begin
                    ovf = 1'b1;
                    if (sat) begin
                        acc = (t > hi) ? hi : lo;
                        clamped = 1'b1;
                    end else begin
                        acc = t & (m - 1);
                        if (sgn && acc > hi) acc -= m;
                    end
                end else begin
                    acc = t;
                end
            end
        end
        return 64'(acc & (m - 1));
    endfunction

    task automatic fill_random(input int n);
        for (int j = 0; j < n; j++) begin
            beat_a[j] = $urandom;
            beat_b[j] = $urandom;
        end
    endtask

    // Offer one beat at the current negedge and wait (bounded) for it to be accepted.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             input logic sat, input logic [7:0] kf, output int waited);
        waited        = 0;
        bm.a_i        = a;
        bm.b_i        = b;
        bm.signed_i   = sgn;
        bm.sat_en_i   = sat;
        bm.k_len_i    = kf;
        bm.in_valid_i = 1'b1;
        #1;
        while (bm.in_ready_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        check("beat_ready", bm.in_ready_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Stream one job, check latency and result on both PEs, then hold the result for 'hold' cycles.
    task automatic run_job(input logic sgn, input logic sat, input logic [7:0] kf, input int hold);
        int          k, waited, lat;
        logic        leak, o32, o18;
        logic [63:0] e32, e18;
        k = (kf == 8'd0) ? 1 : int'(kf);
        for (int j = 0; j < k; j++) begin
            if (j == 0) begin
                send_beat(beat_a[j], beat_b[j], sgn, sat, kf, waited);
            end else begin
                send_beat(beat_a[j], beat_b[j], 1'($urandom), 1'($urandom), 8'($urandom), waited);
                check("no_bubble", waited, 0);
            end
        end
        bm.in_valid_i = 1'b0;
        lat  = 1;
        leak = 1'b0;
        while (bm.out_valid_o !== 1'b1 && lat < 20) begin
            if (bm.in_ready_o !== 1'b0 || bm.busy_o !== 1'b1) leak = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
        end
        check("latency", lat, 3);
        check("drain_ready_low", leak, 0);
        e32 = model(32, sgn, sat, k, o32);
        e18 = model(18, sgn, sat, k, o18);
        check("data32", bm.out_data_o, e32);
        check("ovf32", bm.out_ovf_o, o32);
        check("valid18", bs.out_valid_o, 1'b1);
        check("data18", bs.out_data_o, e18);
        check("ovf18", bs.out_ovf_o, o18);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("bp_valid", bm.out_valid_o, 1'b1);
            check("bp_data", bm.out_data_o, e32);
            check("bp_ready", bm.in_ready_o, 1'b0);
        end
    endtask

    task automatic ack();
        bm.out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bm.out_ready_i = 1'b0;
        check("ack_valid_low", bm.out_valid_o, 1'b0);
        check("ack_ready_high", bm.in_ready_o, 1'b1);
        check("ack_idle", bm.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   waited;
        logic seen;
        bm.a_i = '0; bm.b_i = '0; bm.in_valid_i = 1'b0; bm.signed_i = 1'b0;
        bm.sat_en_i = 1'b0; bm.k_len_i = '0; bm.acc_clr_i = 1'b0; bm.out_ready_i = 1'b0;

        // Reset values.
        #12;
        check("rst_valid", bm.out_valid_o, 1'b0);
        check("rst_data", bm.out_data_o, 0);
        check("rst_ovf", bm.out_ovf_o, 1'b0);
        check("rst_busy", bm.busy_o, 1'b0);
        check("rst_ready", bm.in_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Unsigned, K=1: 1*5+2*6+3*7+4*8 = 70.
        beat_a[0] = 32'h04030201;
        beat_b[0] = 32'h08070605;
        run_job(1'b0, 1'b0, 8'd1, 0);
        check("t1_data", bm.out_data_o, 70);
        check("t1_ovf", bm.out_ovf_o, 1'b0);
        ack();

        // Signed, K=3: 3 beats of 4 * (-1 * 2) = -24.
        for (int j = 0; j < 3; j++) begin
            beat_a[j] = 32'hFFFFFFFF;
            beat_b[j] = 32'h02020202;
        end
        run_job(1'b1, 1'b0, 8'd3, 2);
        check("t2_data", bm.out_data_o, 32'hFFFFFFE8);
        ack();

        // Saturation and wrap on the 18-bit PE: 2 * 260100 exceeds 262143.
        beat_a[0] = 32'hFFFFFFFF; beat_b[0] = 32'hFFFFFFFF;
        beat_a[1] = 32'hFFFFFFFF; beat_b[1] = 32'hFFFFFFFF;
        run_job(1'b0, 1'b1, 8'd2, 0);
        check("sat_data", bs.out_data_o, 262143);
        check("sat_ovf", bs.out_ovf_o, 1'b1);
        ack();
        run_job(1'b0, 1'b0, 8'd2, 0);
        check("wrap_data", bs.out_data_o, 258056);
        check("wrap_ovf", bs.out_ovf_o, 1'b1);
        check("wide_data", bm.out_data_o, 520200);
        ack();

        // Backpressure for 5 cycles, then a back-to-back job.
        fill_random(3);
        run_job(1'($urandom), 1'($urandom), 8'd3, 5);
        ack();
        fill_random(2);
        run_job(1'($urandom), 1'($urandom), 8'd2, 0);
        ack();

        // Abort after beat 2 of a K=4 job while a third beat is offered.
        fill_random(4);
        send_beat(beat_a[0], beat_b[0], 1'b0, 1'b0, 8'd4, waited);
        send_beat(beat_a[1], beat_b[1], 1'b0, 1'b0, 8'd4, waited);
        bm.a_i = $urandom;
        bm.b_i = $urandom;
        bm.in_valid_i = 1'b1;
        bm.acc_clr_i  = 1'b1;
        #1;
        check("clr_ready_low", bm.in_ready_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        bm.acc_clr_i  = 1'b0;
        bm.in_valid_i = 1'b0;
        check("clr_busy", bm.busy_o, 1'b0);
        check("clr_valid", bm.out_valid_o, 1'b0);
        check("clr_data", bm.out_data_o, 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (bm.out_valid_o !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", seen, 1'b0);
        beat_a[0] = 32'h01010101;
        beat_b[0] = 32'h01010101;
        run_job(1'b0, 1'b0, 8'd1, 0);
        check("post_abort_data", bm.out_data_o, 4);
        ack();

        // Asynchronous reset while holding a result.
        fill_random(2);
        run_job(1'($urandom), 1'($urandom), 8'd2, 0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", bm.out_valid_o, 1'b0);
        check("arst_data", bm.out_data_o, 0);
        check("arst_ovf", bm.out_ovf_o, 1'b0);
        check("arst_busy", bm.busy_o, 1'b0);
        check("arst_ready", bm.in_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        beat_a[0] = 32'h02020202; beat_b[0] = 32'h02020202;
        beat_a[1] = 32'h02020202; beat_b[1] = 32'h02020202;
        run_job(1'b0, 1'b0, 8'd2, 0);
        check("post_rst_data", bm.out_data_o, 32);
        ack();

        // Randomized jobs, including k_len 0 (treated as 1) and random hold times.
        for (int n = 0; n < 30; n++) begin
            fill_random(6);
            run_job(1'($urandom), 1'($urandom), 8'($urandom_range(0, 6)), $urandom_range(0, 2));
            ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
